// File: rtl/load_buffer_pkg.sv
// Shared constants for the load path: opcode encodings, bus widths, memory size codes
// and the I/O address boundary.
package load_buffer_pkg;

    localparam int unsigned InstTypeWidth = 3;
    localparam int unsigned ROBWidth      = 4;
    localparam int unsigned AddressWidth  = 32;
    localparam int unsigned DataWidth     = 32;
    localparam int unsigned IDWidth       = 4;

    localparam logic [31:0] LB_IO_BASE = 32'h0003_0000;

    typedef enum logic [InstTypeWidth-1:0] {
        OP_NOP = 3'd0,
        OP_LB  = 3'd1,
        OP_LH  = 3'd2,
        OP_LW  = 3'd3,
        OP_LBU = 3'd4,
        OP_LHU = 3'd5
    } lb_opcode_e;

    localparam logic [1:0] MEM_SIZE_B = 2'd0;
    localparam logic [1:0] MEM_SIZE_H = 2'd1;
    localparam logic [1:0] MEM_SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        LB_IDLE  = 2'd0,
        LB_BUSY  = 2'd1,
        LB_DRAIN = 2'd2
    } lb_state_e;

    function automatic logic [1:0] mem_size_of(input logic [InstTypeWidth-1:0] op);
        case (op)
            OP_LH, OP_LHU: return MEM_SIZE_H;
            OP_LW:         return MEM_SIZE_W;
            default:       return MEM_SIZE_B;
        endcase
    endfunction

endpackage

// File: rtl/lb_if.sv
// Address-unit, memory-controller and CDB-lane signals of the load buffer.
interface lb_if
    import load_buffer_pkg::*;
#(
    parameter int unsigned ROB_WIDTH  = ROBWidth,
    parameter int unsigned ADDR_WIDTH = AddressWidth,
    parameter int unsigned DATA_WIDTH = DataWidth
);
    logic                     addrunit_lbuffer_en_in;
    logic [ADDR_WIDTH-1:0]    addrunit_lbuffer_addr_in;
    logic [ROB_WIDTH-1:0]     addrunit_lbuffer_dest_in;
    logic [InstTypeWidth-1:0] addrunit_lbuffer_opcode_in;
    logic                     lbuffer_mem_req_out;
    logic [ADDR_WIDTH-1:0]    lbuffer_mem_addr_out;
    logic [1:0]               lbuffer_mem_size_out;
    logic                     mem_lbuffer_done_in;
    logic [DATA_WIDTH-1:0]    mem_lbuffer_data_in;
    logic [ROB_WIDTH-1:0]     lbuffer_cdb_b_out;
    logic [DATA_WIDTH-1:0]    lbuffer_cdb_result_out;

    modport master (
        output addrunit_lbuffer_en_in, addrunit_lbuffer_addr_in, addrunit_lbuffer_dest_in,
               addrunit_lbuffer_opcode_in, mem_lbuffer_done_in, mem_lbuffer_data_in,
        input  lbuffer_mem_req_out, lbuffer_mem_addr_out, lbuffer_mem_size_out,
               lbuffer_cdb_b_out, lbuffer_cdb_result_out
    );

    modport slave (
        input  addrunit_lbuffer_en_in, addrunit_lbuffer_addr_in, addrunit_lbuffer_dest_in,
               addrunit_lbuffer_opcode_in, mem_lbuffer_done_in, mem_lbuffer_data_in,
        output lbuffer_mem_req_out, lbuffer_mem_addr_out, lbuffer_mem_size_out,
               lbuffer_cdb_b_out, lbuffer_cdb_result_out
    );
endinterface

// File: rtl/load_buffer_extend.sv
// lb_extend: sign/zero extension of LSB-aligned load data by opcode; shared with store forwarding.
module lb_extend
    import load_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidth
) (
    input  logic [InstTypeWidth-1:0] i_opcode,
    input  logic [DATA_WIDTH-1:0]    i_data,
    output logic [DATA_WIDTH-1:0]    o_result
);
    always_comb begin
        o_result = i_data;
        case (i_opcode)
            OP_LB:   o_result = {{(DATA_WIDTH-8){i_data[7]}}, i_data[7:0]};
            OP_LH:   o_result = {{(DATA_WIDTH-16){i_data[15]}}, i_data[15:0]};
            OP_LBU:  o_result = {{(DATA_WIDTH-8){1'b0}}, i_data[7:0]};
            OP_LHU:  o_result = {{(DATA_WIDTH-16){1'b0}}, i_data[15:0]};
            default: o_result = i_data;
        endcase
    end
endmodule

// File: rtl/load_buffer.sv
// load_buffer: in-order load FIFO issuing one memory read at a time and broadcasting on the CDB.
// Define LOAD_BUFFER_BYPASS_EN to issue an eligible load into an empty idle buffer on its enqueue edge.
//
// state    | meaning
// LB_IDLE  | no read outstanding; issues the head entry once it is eligible
// LB_BUSY  | read for the head entry outstanding; done pops and broadcasts it
// LB_DRAIN | read orphaned by a flush; done is awaited and its data discarded
module load_buffer
    import load_buffer_pkg::*;
#(
    parameter int unsigned           LB_DEPTH   = 8,
    parameter int unsigned           ROB_WIDTH  = ROBWidth,
    parameter int unsigned           ADDR_WIDTH = AddressWidth,
    parameter int unsigned           DATA_WIDTH = DataWidth,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = ADDR_WIDTH'(LB_IO_BASE)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic [ROB_WIDTH-1:0] rob_lbuffer_head_in,
    input  logic                 rob_lbuffer_rst_in,
    output logic                 lbuffer_rs_rdy_out,
    lb_if.slave                  bus
);
    localparam int unsigned PTR_W = $clog2(LB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0]    r_addr [LB_DEPTH];
    logic [ROB_WIDTH-1:0]     r_dest [LB_DEPTH];
    logic [InstTypeWidth-1:0] r_op   [LB_DEPTH];
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [CNT_W-1:0]         r_count;

    lb_state_e                r_state;
    lb_state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0]    r_mem_addr;
    logic [1:0]               r_mem_size;
    logic [ROB_WIDTH-1:0]     r_cdb_b;
    logic [DATA_WIDTH-1:0]    r_cdb_result;

    logic                     w_flush;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_head_elig;
    logic                     w_bypass;
    logic                     w_issue;
    logic [ADDR_WIDTH-1:0]    w_issue_addr;
    logic [InstTypeWidth-1:0] w_issue_op;
    logic [DATA_WIDTH-1:0]    w_ext;

    assign w_flush     = rob_lbuffer_rst_in;
    assign w_push      = bus.addrunit_lbuffer_en_in && !w_flush && (r_count != CNT_W'(LB_DEPTH));
    assign w_head_elig = (r_count != '0) &&
                         ((r_addr[r_head] < IO_BASE) || (r_dest[r_head] == rob_lbuffer_head_in));

`ifdef LOAD_BUFFER_BYPASS_EN
    logic w_in_elig;
    assign w_in_elig = (bus.addrunit_lbuffer_addr_in < IO_BASE) ||
                       (bus.addrunit_lbuffer_dest_in == rob_lbuffer_head_in);
    assign w_bypass  = (r_count == '0) && bus.addrunit_lbuffer_en_in && w_in_elig;
`else
    assign w_bypass  = 1'b0;
`endif

    assign w_issue      = (r_state == LB_IDLE) && !w_flush && (w_head_elig || w_bypass);
    assign w_issue_addr = w_bypass ? bus.addrunit_lbuffer_addr_in : r_addr[r_head];
    assign w_issue_op   = w_bypass ? bus.addrunit_lbuffer_opcode_in : r_op[r_head];
    // A flush racing the completion still pops nothing and suppresses the broadcast.
    assign w_pop        = (r_state == LB_BUSY) && bus.mem_lbuffer_done_in && !w_flush;

    lb_extend #(.DATA_WIDTH(DATA_WIDTH)) u_extend (
        .i_opcode (r_op[r_head]),
        .i_data   (bus.mem_lbuffer_data_in),
        .o_result (w_ext)
    );

    always_ff @(posedge clk_in) begin
        if (rdy_in && w_push) begin
            r_addr[r_tail] <= bus.addrunit_lbuffer_addr_in;
            r_dest[r_tail] <= bus.addrunit_lbuffer_dest_in;
            r_op[r_tail]   <= bus.addrunit_lbuffer_opcode_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (w_flush) begin
                r_head  <= r_tail;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + 1'b1;
                if (w_pop)  r_head <= r_head + 1'b1;
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    // Enqueue into a full buffer means the reservation station ignored rs_rdy.
    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && bus.addrunit_lbuffer_en_in && !w_flush)
            assert (r_count != CNT_W'(LB_DEPTH));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_state <= LB_IDLE;
        else if (rdy_in)
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LB_IDLE:  if (w_issue) w_state_nxt = LB_BUSY;
            LB_BUSY: begin
                if (bus.mem_lbuffer_done_in) w_state_nxt = LB_IDLE;
                else if (w_flush)            w_state_nxt = LB_DRAIN;
            end
            LB_DRAIN: if (bus.mem_lbuffer_done_in) w_state_nxt = LB_IDLE;
            default:  w_state_nxt = LB_IDLE;
        endcase
    end

    always_comb begin
        bus.lbuffer_mem_req_out    = (r_state != LB_IDLE);
        bus.lbuffer_mem_addr_out   = r_mem_addr;
        bus.lbuffer_mem_size_out   = r_mem_size;
        bus.lbuffer_cdb_b_out      = r_cdb_b;
        bus.lbuffer_cdb_result_out = r_cdb_result;
        lbuffer_rs_rdy_out         = (r_count <= CNT_W'(LB_DEPTH - 2));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_mem_addr   <= '0;
            r_mem_size   <= '0;
            r_cdb_b      <= '0;
            r_cdb_result <= '0;
        end else if (rdy_in) begin
            if (w_issue) begin
                r_mem_addr <= w_issue_addr;
                r_mem_size <= mem_size_of(w_issue_op);
            end
            r_cdb_b <= w_pop ? r_dest[r_head] : '0;
            if (w_pop)
                r_cdb_result <= w_ext;
        end
    end

endmodule

// File: tb/tb_load_buffer.sv
// Directed plus randomized bench for load_buffer against a queue-based reference model.
module tb_load_buffer;
    import load_buffer_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  dest;
        logic [2:0]  op;
    } ent_t;

    localparam int DEPTH = 8;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rdy_in;
    logic [3:0] rob_head;
    logic       rob_rst;
    logic       rs_rdy;

    int checks = 0;
    int errors = 0;
    ent_t q[$];

    lb_if bus();

    load_buffer dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .rob_lbuffer_head_in (rob_head),
        .rob_lbuffer_rst_in  (rob_rst),
        .lbuffer_rs_rdy_out  (rs_rdy),
        .bus                 (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [31:0] d);
        int unsigned b = d % 256;
        int unsigned h = d % 65536;
        case (op)
            OP_LB:   return 32'(int'(b) - ((b >= 128) ? 256 : 0));
            OP_LH:   return 32'(int'(h) - ((h >= 32768) ? 65536 : 0));
            OP_LBU:  return 32'(b);
            OP_LHU:  return 32'(h);
            default: return d;
        endcase
    endfunction

    function automatic logic [1:0] ref_size(input logic [2:0] op);
        if (op == OP_LW) return 2'd2;
        if (op == OP_LH || op == OP_LHU) return 2'd1;
        return 2'd0;
    endfunction

    task automatic enq(input logic [31:0] a, input logic [3:0] d, input logic [2:0] op);
        ent_t e;
        bus.addrunit_lbuffer_en_in     = 1'b1;
        bus.addrunit_lbuffer_addr_in   = a;
        bus.addrunit_lbuffer_dest_in   = d;
        bus.addrunit_lbuffer_opcode_in = op;
        step();
        bus.addrunit_lbuffer_en_in = 1'b0;
        e.addr = a;
        e.dest = d;
        e.op   = op;
        q.push_back(e);
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.lbuffer_mem_req_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_wait", bus.lbuffer_mem_req_out, 1);
    endtask

    task automatic serve(input logic [31:0] data);
        ent_t e;
        wait_req();
        e = q.pop_front();
        chk("mem_addr", bus.lbuffer_mem_addr_out, e.addr);
        chk("mem_size", bus.lbuffer_mem_size_out, ref_size(e.op));
        chk("cdb_b_idle", bus.lbuffer_cdb_b_out, 0);
        bus.mem_lbuffer_done_in = 1'b1;
        bus.mem_lbuffer_data_in = data;
        step();
        bus.mem_lbuffer_done_in = 1'b0;
        chk("cdb_b", bus.lbuffer_cdb_b_out, e.dest);
        chk("cdb_result", bus.lbuffer_cdb_result_out, ref_ext(e.op, data));
        step();
        chk("cdb_b_after", bus.lbuffer_cdb_b_out, 0);
    endtask

    function automatic logic [2:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return OP_LB;
            1:       return OP_LH;
            2:       return OP_LW;
            3:       return OP_LBU;
            default: return OP_LHU;
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        logic [3:0]  d;
        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        rob_head = 4'd0;
        rob_rst  = 1'b0;
        bus.addrunit_lbuffer_en_in     = 1'b0;
        bus.addrunit_lbuffer_addr_in   = '0;
        bus.addrunit_lbuffer_dest_in   = '0;
        bus.addrunit_lbuffer_opcode_in = '0;
        bus.mem_lbuffer_done_in        = 1'b0;
        bus.mem_lbuffer_data_in        = '0;
        step();
        step();
        rst_in = 1'b0;
        chk("rst_req", bus.lbuffer_mem_req_out, 0);
        chk("rst_addr", bus.lbuffer_mem_addr_out, 0);
        chk("rst_size", bus.lbuffer_mem_size_out, 0);
        chk("rst_b", bus.lbuffer_cdb_b_out, 0);
        chk("rst_result", bus.lbuffer_cdb_result_out, 0);
        chk("rst_rs_rdy", rs_rdy, 1);

        // single LW with issue latency
        enq(32'h100, 4'd3, OP_LW);
        chk("lw_no_early_req", bus.lbuffer_mem_req_out, 0);
        step();
        chk("lw_req", bus.lbuffer_mem_req_out, 1);
        chk("lw_size", bus.lbuffer_mem_size_out, 2);
        step();
        chk("lw_req_held", bus.lbuffer_mem_req_out, 1);
        serve(32'hDEADBEEF);

        // extension corners
        enq(32'h104, 4'd1, OP_LB);   serve(32'h80);
        enq(32'h108, 4'd2, OP_LBU);  serve(32'h80);
        enq(32'h10C, 4'd4, OP_LH);   serve(32'h8001);
        enq(32'h110, 4'd5, OP_LHU);  serve(32'h8001);

        // fill to the ready boundary and beyond, then drain across a pointer wrap
        for (int i = 0; i < DEPTH; i++) begin
            enq($urandom_range(0, 32'h2FFFF), 4'($urandom_range(1, 15)), rand_op());
            chk("rs_rdy_fill", rs_rdy, (DEPTH - q.size()) >= 2);
        end
        for (int i = 0; i < DEPTH; i++) serve($urandom);
        chk("rs_rdy_empty", rs_rdy, 1);
        for (int i = 0; i < 4; i++)
            enq($urandom_range(0, 32'h2FFFF), 4'($urandom_range(1, 15)), rand_op());
        for (int i = 0; i < 4; i++) serve($urandom);

        // I/O load waits for the ROB head
        rob_head = 4'd2;
        enq(32'h30000, 4'd5, OP_LW);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("io_blocked", bus.lbuffer_mem_req_out, 0);
        end
        rob_head = 4'd5;
        step();
        chk("io_issue", bus.lbuffer_mem_req_out, 1);
        serve($urandom);
        enq(32'h2FFFC, 4'd7, OP_LW);
        serve($urandom);

        // enqueue ignored while rdy_in is low
        rdy_in = 1'b0;
        enq(32'h200, 4'd8, OP_LW);
        void'(q.pop_back());
        rdy_in = 1'b1;
        step();
        step();
        chk("rdy_low_no_enq", bus.lbuffer_mem_req_out, 0);

        // flush while BUSY, with a competing enqueue
        enq(32'h200, 4'd6, OP_LW);
        wait_req();
        enq(32'h204, 4'd7, OP_LW);
        rob_rst = 1'b1;
        bus.addrunit_lbuffer_en_in     = 1'b1;
        bus.addrunit_lbuffer_addr_in   = 32'h208;
        bus.addrunit_lbuffer_dest_in   = 4'd9;
        bus.addrunit_lbuffer_opcode_in = OP_LW;
        step();
        rob_rst = 1'b0;
        bus.addrunit_lbuffer_en_in = 1'b0;
        q.delete();
        chk("drain_req_held", bus.lbuffer_mem_req_out, 1);
        chk("drain_rs_rdy", rs_rdy, 1);
        chk("drain_b", bus.lbuffer_cdb_b_out, 0);
        step();
        step();
        bus.mem_lbuffer_done_in = 1'b1;
        bus.mem_lbuffer_data_in = $urandom;
        step();
        bus.mem_lbuffer_done_in = 1'b0;
        chk("drain_done_b", bus.lbuffer_cdb_b_out, 0);
        chk("drain_done_req", bus.lbuffer_mem_req_out, 0);
        step();
        step();
        chk("flush_emptied", bus.lbuffer_mem_req_out, 0);
        chk("flush_b_quiet", bus.lbuffer_cdb_b_out, 0);
        enq(32'h20C, 4'd10, OP_LH);
        serve($urandom);

        // reset with a read in flight
        enq(32'h300, 4'd11, OP_LW);
        wait_req();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        q.delete();
        chk("rst_busy_req", bus.lbuffer_mem_req_out, 0);
        chk("rst_busy_b", bus.lbuffer_cdb_b_out, 0);
        chk("rst_busy_rs_rdy", rs_rdy, 1);
        bus.mem_lbuffer_done_in = 1'b1;
        bus.mem_lbuffer_data_in = $urandom;
        step();
        bus.mem_lbuffer_done_in = 1'b0;
        chk("stray_done_b", bus.lbuffer_cdb_b_out, 0);
        chk("stray_done_req", bus.lbuffer_mem_req_out, 0);

        // randomized bursts mixing memory and I/O loads
        for (int burst = 0; burst < 6; burst++) begin
            int k;
            k = $urandom_range(1, 4);
            rob_head = 4'($urandom_range(1, 15));
            for (int i = 0; i < k; i++) begin
                a = $urandom_range(0, 32'h3FFFF);
                d = (a >= 32'h30000) ? rob_head : 4'($urandom_range(1, 15));
                enq(a, d, rand_op());
            end
            for (int i = 0; i < k; i++) serve($urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
